// File: rtl/ms_cpu_pkg.sv
// ms_cpu_pkg: shared halfword width, command-length and fetch-state encodings
package ms_cpu_pkg;
  localparam int HwW = 16;
  typedef enum logic [1:0] {LenBad, Len1, Len2, Len3} cmdLen_e;
  typedef enum logic [1:0] {FsIdle, FsReq, FsWait} fetchState_e;
endpackage

// File: rtl/ms_cmd_queue_if.sv
// ms_cmd_queue_if: decoder-side and code-memory-side signals of the prefetch queue
interface ms_cmd_queue_if #(parameter int QDepth = 8);
  import ms_cpu_pkg::*;
  logic AIpLoad;
  logic [23:1] AIpNew;
  logic [3*HwW-1:0] AQueTop;
  logic [23:1] AIpThis;
  logic [$clog2(QDepth):0] AQueCnt;
  logic [1:0] ACmdLen;
  logic ACmdLenValid;
  logic AQueShift;
  logic AFetchReq;
  logic [23:2] AFetchAddr;
  logic AFetchAck;
  logic AFetchDataVld;
  logic [31:0] AFetchData;
  modport master (
    input AIpLoad, AIpNew, ACmdLen, AQueShift, AFetchAck, AFetchDataVld, AFetchData,
    output AQueTop, AIpThis, AQueCnt, ACmdLenValid, AFetchReq, AFetchAddr
  );
  modport slave (
    output AIpLoad, AIpNew, ACmdLen, AQueShift, AFetchAck, AFetchDataVld, AFetchData,
    input AQueTop, AIpThis, AQueCnt, ACmdLenValid, AFetchReq, AFetchAddr
  );
endinterface

// File: rtl/ms_hw_fifo.sv
// ms_hw_fifo: halfword circular buffer, 1-or-2 write, 1..3 read, 3-slot peek window
module ms_hw_fifo import ms_cpu_pkg::*; #(
  parameter int Depth = 8,
  localparam int PW = $clog2(Depth),
  localparam int CW = PW + 1
) (
  input  logic clk,
  input  logic resetN,
  input  logic flush,
  input  logic [1:0] wrCnt,
  input  logic [HwW-1:0] wrLo,
  input  logic [HwW-1:0] wrHi,
  input  logic [1:0] rdLen,
  output logic [3*HwW-1:0] peek,
  output logic [CW-1:0] cnt
);
  logic [HwW-1:0] mem [Depth];
  logic [PW-1:0] rp, wp;
  always_ff @(posedge clk) begin
    if (!resetN || flush) begin
      rp <= '0;
      wp <= '0;
      cnt <= '0;
    end else begin
      rp <= rp + PW'(rdLen);
      wp <= wp + PW'(wrCnt);
      cnt <= cnt + CW'(wrCnt) - CW'(rdLen);
    end
  end
  always_ff @(posedge clk) begin
    if (wrCnt != 2'd0) mem[wp] <= wrLo;
    if (wrCnt == 2'd2) mem[wp + PW'(1)] <= wrHi;
  end
  // slots beyond the valid count read as zero so stale halfwords never leak out
  always_comb begin
    peek = '0;
    for (int i = 0; i < 3; i++) peek[i*HwW +: HwW] = (CW'(i) < cnt) ? mem[rp + PW'(i)] : '0;
  end
endmodule

// File: rtl/ms_cmd_queue.sv
// ms_cmd_queue: instruction prefetch queue feeding the command decoder
module ms_cmd_queue import ms_cpu_pkg::*; #(
  parameter int QDepth = 8,
  parameter logic [23:1] ResetIp = 23'h0
) (
  input logic AClkH,
  input logic AResetHN,
  ms_cmd_queue_if.master q
);
  localparam int CW = $clog2(QDepth) + 1;
  fetchState_e state, stateNext;
  logic [23:2] fetchPtr, reqAddr;
  logic [23:1] ipThis;
  logic [CW-1:0] cnt;
  logic skip, drop, vld, wr, consume, freeOk;
  always_comb begin
    vld = q.AFetchDataVld && state == FsWait;
    wr = vld && !drop && !q.AIpLoad;
    consume = q.AQueShift && q.ACmdLenValid && !q.AIpLoad;
    freeOk = cnt <= CW'(QDepth - 2);
  end
  always_ff @(posedge AClkH) state <= !AResetHN ? FsIdle : stateNext;
  always_comb begin
    stateNext = state == FsIdle ? (!q.AIpLoad && freeOk ? FsReq : FsIdle)
              : state == FsReq ? (q.AFetchAck ? FsWait : FsReq)
              : (vld ? FsIdle : FsWait);
  end
  always_comb begin
    q.AFetchReq = state == FsReq;
    q.AFetchAddr = reqAddr;
    q.AIpThis = ipThis;
    q.AQueCnt = cnt;
    q.ACmdLenValid = q.ACmdLen != LenBad && cnt >= CW'(q.ACmdLen);
  end
  // reqAddr freezes the address so a redirect in Req never changes an issued request
  always_ff @(posedge AClkH) begin
    if (!AResetHN) begin
      ipThis <= ResetIp;
      fetchPtr <= ResetIp[23:2];
      reqAddr <= ResetIp[23:2];
      skip <= ResetIp[1];
      drop <= 1'b0;
    end else begin
      ipThis <= q.AIpLoad ? q.AIpNew : consume ? ipThis + 23'(q.ACmdLen) : ipThis;
      fetchPtr <= q.AIpLoad ? q.AIpNew[23:2] : wr ? fetchPtr + 22'd1 : fetchPtr;
      skip <= q.AIpLoad ? q.AIpNew[1] : wr ? 1'b0 : skip;
      drop <= q.AIpLoad ? (state == FsReq || (state == FsWait && !vld)) : vld ? 1'b0 : drop;
      reqAddr <= (state == FsIdle && stateNext == FsReq) ? fetchPtr : reqAddr;
    end
  end
  ms_hw_fifo #(.Depth(QDepth)) fifo (
    .clk(AClkH),
    .resetN(AResetHN),
    .flush(q.AIpLoad),
    .wrCnt(wr ? (skip ? 2'd1 : 2'd2) : 2'd0),
    .wrLo(skip ? q.AFetchData[31:16] : q.AFetchData[15:0]),
    .wrHi(q.AFetchData[31:16]),
    .rdLen(consume ? q.ACmdLen : 2'd0),
    .peek(q.AQueTop),
    .cnt(cnt)
  );
endmodule

// File: tb/tb_ms_cmd_queue.sv
// tb_ms_cmd_queue: directed checks of fill, consume, redirect and reset behaviour
module tb_ms_cmd_queue;
  logic clk = 1'b0;
  logic rstN = 1'b0;
  int cmpCnt = 0;
  int errCnt = 0;
  always #5 clk = ~clk;
  ms_cmd_queue_if #(.QDepth(8)) q();
  ms_cmd_queue #(.QDepth(8), .ResetIp(23'h0)) dut (.AClkH(clk), .AResetHN(rstN), .q(q));

  // code memory contents: halfword h holds 16'h1111 * (h[3:0] + 1)
  function automatic logic [15:0] hwVal(int h);
    logic [3:0] l;
    l = h[3:0];
    return 16'h1111 * (16'(l) + 16'd1);
  endfunction
  function automatic logic [31:0] memWord(logic [21:0] a);
    int h;
    h = int'(a) * 2;
    return {hwVal(h + 1), hwVal(h)};
  endfunction

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    cmpCnt++;
    if (got !== exp) begin
      errCnt++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(negedge clk);
  endtask
  task automatic waitReq(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (q.AFetchReq) ok = 1'b1;
      else tick();
    end
    check("reqSeen", 64'(ok), 64'd1);
  endtask
  task automatic serve(input int ackDly, input logic [21:0] addr, input bit shiftOnVld);
    bit ok;
    waitReq(ok);
    check("fetchAddr", 64'(q.AFetchAddr), 64'(addr));
    for (int i = 0; i < ackDly; i++) begin
      tick();
      check("reqHeld", 64'({q.AFetchReq, q.AFetchAddr}), 64'({1'b1, addr}));
    end
    q.AFetchAck = 1'b1;
    tick();
    q.AFetchAck = 1'b0;
    q.AFetchData = memWord(addr);
    q.AFetchDataVld = 1'b1;
    q.AQueShift = shiftOnVld;
    tick();
    q.AFetchDataVld = 1'b0;
    q.AQueShift = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bit ok;
    q.AIpLoad = 1'b0;
    q.AIpNew = '0;
    q.ACmdLen = 2'd0;
    q.AQueShift = 1'b0;
    q.AFetchAck = 1'b0;
    q.AFetchDataVld = 1'b0;
    q.AFetchData = '0;
    repeat (3) tick();
    check("rstCnt", 64'(q.AQueCnt), 64'd0);
    check("rstTop", 64'(q.AQueTop), 64'd0);
    check("rstLenVld", 64'(q.ACmdLenValid), 64'd0);
    check("rstIp", 64'(q.AIpThis), 64'd0);
    check("rstReq", 64'(q.AFetchReq), 64'd0);
    rstN = 1'b1;
    // fill from reset until the queue is full
    serve(0, 22'd0, 1'b0);
    check("fill1Cnt", 64'(q.AQueCnt), 64'd2);
    serve(0, 22'd1, 1'b0);
    check("fill2Top", 64'(q.AQueTop), 64'h3333_2222_1111);
    check("fill2Cnt", 64'(q.AQueCnt), 64'd4);
    serve(0, 22'd2, 1'b0);
    serve(0, 22'd3, 1'b0);
    repeat (5) tick();
    check("fullCnt", 64'(q.AQueCnt), 64'd8);
    check("fullNoReq", 64'(q.AFetchReq), 64'd0);
    // consume 3 halfwords per cycle
    q.ACmdLen = 2'd3;
    q.AQueShift = 1'b1;
    #1;
    check("lenVld", 64'(q.ACmdLenValid), 64'd1);
    tick();
    check("c1Ip", 64'(q.AIpThis), 64'd3);
    check("c1Top", 64'(q.AQueTop), 64'h6666_5555_4444);
    check("c1Cnt", 64'(q.AQueCnt), 64'd5);
    tick();
    check("c2Ip", 64'(q.AIpThis), 64'd6);
    check("c2Top", 64'(q.AQueTop), 64'h0000_8888_7777);
    check("c2Cnt", 64'(q.AQueCnt), 64'd2);
    tick();
    check("shortIp", 64'(q.AIpThis), 64'd6);
    check("shortCnt", 64'(q.AQueCnt), 64'd2);
    check("shortLenVld", 64'(q.ACmdLenValid), 64'd0);
    q.AQueShift = 1'b0;
    q.ACmdLen = 2'd0;
    check("pendReq", 64'({q.AFetchReq, q.AFetchAddr}), 64'({1'b1, 22'd4}));
    // redirect to an odd halfword while a request is pending
    q.AIpLoad = 1'b1;
    q.AIpNew = 23'h11;
    tick();
    q.AIpLoad = 1'b0;
    check("rdCnt", 64'(q.AQueCnt), 64'd0);
    check("rdIp", 64'(q.AIpThis), 64'h11);
    serve(3, 22'd4, 1'b0);
    check("dropCnt", 64'(q.AQueCnt), 64'd0);
    serve(0, 22'h8, 1'b0);
    check("oddCnt", 64'(q.AQueCnt), 64'd1);
    check("oddTop", 64'(q.AQueTop), 64'h0000_0000_2222);
    check("oddIp", 64'(q.AIpThis), 64'h11);
    serve(0, 22'h9, 1'b0);
    check("w9Top", 64'(q.AQueTop), 64'h4444_3333_2222);
    // write and consume in the same cycle
    q.ACmdLen = 2'd1;
    serve(0, 22'hA, 1'b1);
    check("simCnt", 64'(q.AQueCnt), 64'd4);
    check("simIp", 64'(q.AIpThis), 64'h12);
    check("simTop", 64'(q.AQueTop), 64'h5555_4444_3333);
    q.ACmdLen = 2'd0;
    // reset in Wait
    waitReq(ok);
    q.AFetchAck = 1'b1;
    tick();
    q.AFetchAck = 1'b0;
    rstN = 1'b0;
    tick();
    check("wrstCnt", 64'(q.AQueCnt), 64'd0);
    check("wrstTop", 64'(q.AQueTop), 64'd0);
    check("wrstIp", 64'(q.AIpThis), 64'd0);
    check("wrstReq", 64'(q.AFetchReq), 64'd0);
    check("wrstLenVld", 64'(q.ACmdLenValid), 64'd0);
    rstN = 1'b1;
    serve(0, 22'd0, 1'b0);
    check("postRstTop", 64'(q.AQueTop), 64'h0000_2222_1111);
    // redirect in Wait drops the outstanding response
    waitReq(ok);
    check("w1Addr", 64'(q.AFetchAddr), 64'd1);
    q.AFetchAck = 1'b1;
    tick();
    q.AFetchAck = 1'b0;
    q.AIpLoad = 1'b1;
    q.AIpNew = 23'h20;
    tick();
    q.AIpLoad = 1'b0;
    check("wrdCnt", 64'(q.AQueCnt), 64'd0);
    check("wrdIp", 64'(q.AIpThis), 64'h20);
    q.AFetchData = memWord(22'd1);
    q.AFetchDataVld = 1'b1;
    tick();
    q.AFetchDataVld = 1'b0;
    check("wdropCnt", 64'(q.AQueCnt), 64'd0);
    serve(0, 22'h10, 1'b0);
    check("newCnt", 64'(q.AQueCnt), 64'd2);
    check("newTop", 64'(q.AQueTop), 64'h0000_2222_1111);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCnt, errCnt);
    $finish;
  end
endmodule
